// File: rtl/apple2_disk_pkg.sv
// Shared types and constants for the floppy track-buffer controller.
package apple2_disk_pkg;

  localparam int SECTORS_DEF = 13;
  localparam int LBA_W       = 32;
  localparam int SEC_W       = 4;
  localparam int TRACK_W     = 6;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FLUSH_REQ  = 3'd1,
    FLUSH_XFER = 3'd2,
    LOAD_REQ   = 3'd3,
    LOAD_XFER  = 3'd4
  } fdd_state_t;

  // Track images are packed back to back, so the LBA is linear in track.
  function automatic logic [LBA_W-1:0] sector_lba(input logic [TRACK_W-1:0] trk,
                                                  input logic [SEC_W-1:0]   sec,
                                                  input int                 sectors);
    return LBA_W'(sectors) * LBA_W'(trk) + LBA_W'(sec);
  endfunction

endpackage

// File: rtl/fdd_track_ctrl_if.sv
// SD sector channel between the track controller and the SD block.
// A request (sd_rd or sd_wr) stays high with stable sd_lba/track_sec until sd_ack rises;
// it drops the cycle after that rise, and the falling edge of sd_ack marks the sector done.
interface fdd_track_ctrl_if;
  import apple2_disk_pkg::*;

  logic [LBA_W-1:0] sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic [SEC_W-1:0] track_sec;
  logic             sd_ack;

  modport master (
    output sd_lba,
    output sd_rd,
    output sd_wr,
    output track_sec,
    input  sd_ack
  );

  modport slave (
    input  sd_lba,
    input  sd_rd,
    input  sd_wr,
    input  track_sec,
    output sd_ack
  );

endinterface

// File: rtl/fdd_dirty_pick.sv
// Lowest-set-bit encoder over the dirty sector mask.
module fdd_dirty_pick
  import apple2_disk_pkg::*;
#(
  parameter int N = SECTORS_DEF
) (
  input  logic [N-1:0]     mask,
  output logic [SEC_W-1:0] idx,
  output logic             any
);

  // Scanning downwards lets the lowest set bit be the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = SEC_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fdd_track_ctrl.sv
// Track-buffer controller: flushes dirty sectors and loads whole tracks over the SD channel
// on head movement, image mount, or after a period without disk writes.
module fdd_track_ctrl
  import apple2_disk_pkg::*;
#(
  parameter int SECTORS    = SECTORS_DEF,
  parameter int IDLE_FLUSH = 1400000
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [TRACK_W-1:0] track,
  input  logic               img_mounted,
  input  logic               img_size_nz,
  input  logic               img_readonly,
  input  logic               fd_write_disk,
  input  logic [13:0]        fd_track_addr,
  fdd_track_ctrl_if.master   sd,
  output logic               cpu_wait,
  output logic               busy,
  output fdd_state_t         state_dbg
);

  localparam int CNT_W = $clog2(IDLE_FLUSH + 1);

  fdd_state_t         state, state_n;
  logic [SECTORS-1:0] dirty, dirty_n;
  logic [TRACK_W-1:0] cur_track, cur_track_n;
  logic [TRACK_W-1:0] track_latched, trk_lat_n;
  logic               valid, valid_n;
  logic               pend_mount, pend_n;
  logic               bg_flush, bg_n;
  logic [SEC_W-1:0]   xfer_sec, sec_n;
  logic [CNT_W-1:0]   idle_cnt, idle_cnt_n;
  logic               ack_q;

  logic               ack_rise, ack_fall;
  logic [SEC_W-1:0]   wr_sec;
  logic               wr_acc;
  logic               in_load;
  logic               pend_now;
  logic               want;
  logic               go_load;
  logic               idle_hit;
  logic [SEC_W-1:0]   pick_idx;
  logic               pick_any;
  logic               unused_addr_bits;

  fdd_dirty_pick #(.N(SECTORS)) u_pick (
    .mask (dirty),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign unused_addr_bits = ^{fd_track_addr[13], fd_track_addr[8:0]};

  assign ack_rise = sd.sd_ack & ~ack_q;
  assign ack_fall = ~sd.sd_ack & ack_q;
  assign wr_sec   = fd_track_addr[12:9];
  assign in_load  = (state == LOAD_REQ) || (state == LOAD_XFER);
  assign wr_acc   = fd_write_disk && valid && !img_readonly && !in_load &&
                    ({1'b0, wr_sec} < (SEC_W + 1)'(SECTORS));
  // A mount arriving this cycle already counts as pending, so no stale flush starts.
  assign pend_now = pend_mount | img_mounted;
  assign want     = (track != cur_track) || pend_now;
  assign idle_hit = (idle_cnt == CNT_W'(IDLE_FLUSH));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state         <= IDLE;
      dirty         <= '0;
      cur_track     <= '1;
      track_latched <= '0;
      valid         <= 1'b0;
      pend_mount    <= 1'b0;
      bg_flush      <= 1'b0;
      xfer_sec      <= '0;
      idle_cnt      <= '0;
      ack_q         <= 1'b0;
    end else begin
      state         <= state_n;
      dirty         <= dirty_n;
      cur_track     <= cur_track_n;
      track_latched <= trk_lat_n;
      valid         <= valid_n;
      pend_mount    <= pend_n;
      bg_flush      <= bg_n;
      xfer_sec      <= sec_n;
      idle_cnt      <= idle_cnt_n;
      ack_q         <= sd.sd_ack;
    end
  end

  always_comb begin
    state_n     = state;
    dirty_n     = dirty;
    cur_track_n = cur_track;
    trk_lat_n   = track_latched;
    valid_n     = valid;
    pend_n      = pend_mount;
    bg_n        = bg_flush;
    sec_n       = xfer_sec;
    go_load     = 1'b0;

    if (wr_acc) begin
      idle_cnt_n = '0;
    end else if (!idle_hit) begin
      idle_cnt_n = idle_cnt + 1'b1;
    end else begin
      idle_cnt_n = idle_cnt;
    end

    // Clear on the write ack first so a simultaneous strobe to the same sector wins.
    if (state == FLUSH_REQ && ack_rise) dirty_n[xfer_sec] = 1'b0;
    if (wr_acc)                         dirty_n[wr_sec]   = 1'b1;
    if (img_mounted) begin
      dirty_n = '0;
      valid_n = 1'b0;
      pend_n  = 1'b1;
    end

    case (state)
      IDLE: begin
        if (want) begin
          if (pick_any && !pend_now) begin
            state_n = FLUSH_REQ;
            sec_n   = pick_idx;
            bg_n    = 1'b0;
          end else begin
            go_load = 1'b1;
          end
        end else if (pick_any && idle_hit) begin
          state_n = FLUSH_REQ;
          sec_n   = pick_idx;
          bg_n    = 1'b1;
        end
      end
      FLUSH_REQ: begin
        if (ack_rise) state_n = FLUSH_XFER;
      end
      FLUSH_XFER: begin
        if (ack_fall) begin
          if (pend_now) begin
            go_load = 1'b1;
          end else if (pick_any) begin
            state_n = FLUSH_REQ;
            sec_n   = pick_idx;
          end else if (bg_flush) begin
            state_n = IDLE;
          end else begin
            go_load = 1'b1;
          end
        end
      end
      LOAD_REQ: begin
        if (ack_rise) state_n = LOAD_XFER;
      end
      LOAD_XFER: begin
        if (ack_fall) begin
          if (pend_now) begin
            go_load = 1'b1;
          end else if (xfer_sec == SEC_W'(SECTORS - 1)) begin
            state_n     = IDLE;
            valid_n     = 1'b1;
            cur_track_n = track_latched;
          end else begin
            state_n = LOAD_REQ;
            sec_n   = xfer_sec + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // An empty image has nothing to load; adopting the track stops re-detection.
    if (go_load) begin
      pend_n = 1'b0;
      bg_n   = 1'b0;
      if (img_size_nz) begin
        state_n   = LOAD_REQ;
        trk_lat_n = track;
        sec_n     = '0;
      end else begin
        state_n     = IDLE;
        valid_n     = 1'b0;
        cur_track_n = track;
      end
    end
  end

  always_comb begin
    sd.sd_rd     = (state == LOAD_REQ);
    sd.sd_wr     = (state == FLUSH_REQ);
    sd.sd_lba    = '0;
    sd.track_sec = '0;
    case (state)
      FLUSH_REQ, FLUSH_XFER: begin
        sd.sd_lba    = sector_lba(cur_track, xfer_sec, SECTORS);
        sd.track_sec = xfer_sec;
      end
      LOAD_REQ, LOAD_XFER: begin
        sd.sd_lba    = sector_lba(track_latched, xfer_sec, SECTORS);
        sd.track_sec = xfer_sec;
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign cpu_wait  = !reset && ((state == IDLE) ? ((state_n != IDLE) && !bg_n) : !bg_flush);
  assign state_dbg = state;

endmodule

// File: tb/tb_fdd_track_ctrl.sv
// Directed and randomized checks of the track controller against a sector-list reference model.
module tb_fdd_track_ctrl;
  import apple2_disk_pkg::*;

  localparam int NS  = 13;
  localparam int IFL = 300;
  localparam int W   = 38;

  logic         clk_sys = 1'b0;
  logic         reset   = 1'b1;
  logic [5:0]   track   = 6'd0;
  logic         img_mounted   = 1'b0;
  logic         img_size_nz   = 1'b0;
  logic         img_readonly  = 1'b0;
  logic         fd_write_disk = 1'b0;
  logic [13:0]  fd_track_addr = 14'd0;
  logic         cpu_wait, busy;
  fdd_state_t   state_dbg;

  fdd_track_ctrl_if sd_bus();

  fdd_track_ctrl #(.SECTORS(NS), .IDLE_FLUSH(IFL)) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .track         (track),
    .img_mounted   (img_mounted),
    .img_size_nz   (img_size_nz),
    .img_readonly  (img_readonly),
    .fd_write_disk (fd_write_disk),
    .fd_track_addr (fd_track_addr),
    .sd            (sd_bus),
    .cpu_wait      (cpu_wait),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  always #5 clk_sys = ~clk_sys;

  // Expected request record: {is_write, cpu_wait, track_sec, lba}
  logic [W-1:0] exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   fg_mode = 1'b0;
  bit   cw_low_seen = 1'b0;

  bit [15:0] m_dirty = '0;
  int        m_cur   = 63;
  bit        m_valid = 1'b0;
  bit        m_nz    = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (fg_mode && busy && !cpu_wait) cw_low_seen = 1'b1;
  endtask

  function automatic logic [W-1:0] rec(input bit wr, input bit cw, input int sec, input int lba);
    return {wr, cw, 4'(sec), 32'(lba)};
  endfunction

  task automatic model_track_check();
    if (int'(track) != m_cur) begin
      if (m_nz) begin
        for (int s = 0; s < NS; s++)
          if (m_dirty[s]) exp_q.push_back(rec(1'b1, 1'b1, s, NS * m_cur + s));
        for (int s = 0; s < NS; s++)
          exp_q.push_back(rec(1'b0, 1'b1, s, NS * int'(track) + s));
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      m_dirty = '0;
      m_cur   = int'(track);
    end
  endtask

  // Acts as the SD block: acknowledges each request with random latency and checks it.
  task automatic serve(input int bound, input bit fg, input int strobe_sec);
    logic [W-1:0] got;
    bit first = 1'b1;
    int waited;
    fg_mode = fg;
    cw_low_seen = 1'b0;
    while (exp_q.size() > 0) begin
      waited = 0;
      while (!(sd_bus.sd_rd || sd_bus.sd_wr) && waited < bound) begin
        tick();
        waited++;
      end
      if (!(sd_bus.sd_rd || sd_bus.sd_wr)) begin
        chk("req_timeout", rec(1'b0, 1'b0, 0, exp_q.size()), rec(1'b0, 1'b0, 0, 0));
        exp_q.delete();
        break;
      end
      got = {sd_bus.sd_wr, cpu_wait, sd_bus.track_sec, sd_bus.sd_lba};
      chk("xfer", got, exp_q.pop_front());
      repeat ($urandom_range(0, 2)) tick();
      sd_bus.sd_ack = 1'b1;
      if (first && strobe_sec >= 0) begin
        fd_track_addr = {1'b0, 4'(strobe_sec), 9'($urandom_range(0, 511))};
        fd_write_disk = 1'b1;
      end
      first = 1'b0;
      tick();
      fd_write_disk = 1'b0;
      chk("req_drop", W'({sd_bus.sd_rd, sd_bus.sd_wr}), W'(0));
      repeat ($urandom_range(0, 2)) tick();
      sd_bus.sd_ack = 1'b0;
      tick();
    end
    waited = 0;
    while (busy && waited < 50) begin
      tick();
      waited++;
    end
    chk("idle_busy", W'(busy), W'(0));
    chk("idle_cpu_wait", W'(cpu_wait), W'(0));
    if (fg) chk("cpu_wait_held", W'(cw_low_seen), W'(0));
    fg_mode = 1'b0;
  endtask

  task automatic do_write(input int s);
    fd_track_addr = {1'($urandom), 4'(s), 9'($urandom_range(0, 511))};
    fd_write_disk = 1'b1;
    tick();
    fd_write_disk = 1'b0;
    if (m_valid && !img_readonly && s < NS) m_dirty[s] = 1'b1;
  endtask

  task automatic change_track(input int t);
    track = 6'(t);
    model_track_check();
    tick();
    serve(50, 1'b1, -1);
  endtask

  task automatic mount(input bit nz);
    img_size_nz = nz;
    img_mounted = 1'b1;
    m_dirty = '0;
    m_nz    = nz;
    m_cur   = int'(track);
    m_valid = nz;
    if (nz)
      for (int s = 0; s < NS; s++) exp_q.push_back(rec(1'b0, 1'b1, s, NS * int'(track) + s));
    tick();
    img_mounted = 1'b0;
    serve(50, 1'b1, -1);
  endtask

  initial begin
    sd_bus.sd_ack = 1'b0;
    repeat (3) tick();
    chk("rst_sd_rd", W'(sd_bus.sd_rd), W'(0));
    chk("rst_sd_wr", W'(sd_bus.sd_wr), W'(0));
    chk("rst_cpu_wait", W'(cpu_wait), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_lba", W'(sd_bus.sd_lba), W'(0));
    chk("rst_track_sec", W'(sd_bus.track_sec), W'(0));
    chk("rst_state", W'(state_dbg), W'(IDLE));

    reset = 1'b0;
    model_track_check();
    tick();
    serve(50, 1'b1, -1);

    // First mount loads track 0
    mount(1'b1);

    // Dirty sectors are flushed before the next track loads
    change_track(5);
    do_write(3);
    do_write(7);
    change_track(6);

    // Background flush after the idle period
    do_write(2);
    repeat (IFL - 2) tick();
    chk("no_early_flush", W'(sd_bus.sd_wr), W'(0));
    exp_q.push_back(rec(1'b1, 1'b0, 2, NS * m_cur + 2));
    serve(30, 1'b0, -1);
    m_dirty = '0;
    change_track(7);

    // Write strobe racing the flush ack re-dirties the sector
    do_write(4);
    exp_q.push_back(rec(1'b1, 1'b0, 4, NS * m_cur + 4));
    exp_q.push_back(rec(1'b1, 1'b0, 4, NS * m_cur + 4));
    serve(IFL + 30, 1'b0, 4);
    m_dirty = '0;

    // Read-only image ignores writes
    img_readonly = 1'b1;
    do_write(1);
    do_write(5);
    do_write(12);
    change_track(8);
    img_readonly = 1'b0;

    // Mount discards dirty data and reloads
    do_write(0);
    do_write(9);
    mount(1'b1);

    // Empty image: no loads, no stall
    mount(1'b0);
    do_write(3);
    change_track(9);
    repeat (5) tick();
    chk("empty_busy", W'(busy), W'(0));
    mount(1'b1);

    // Randomized write/track-change rounds
    for (int r = 0; r < 8; r++) begin
      img_readonly = ($urandom_range(0, 3) == 0);
      for (int k = $urandom_range(0, 4); k > 0; k--) do_write($urandom_range(0, 15));
      img_readonly = 1'b0;
      change_track((m_cur + 1 + $urandom_range(0, 40)) % 64);
    end

    // Highest track and out-of-range sectors
    do_write(12);
    do_write(13);
    do_write(15);
    if (m_cur == 63) change_track(0);
    change_track(63);

    // Reset while a read is outstanding
    track = 6'd20;
    begin
      int waited = 0;
      while (!sd_bus.sd_rd && waited < 20) begin
        tick();
        waited++;
      end
    end
    chk("rd_before_rst", W'(sd_bus.sd_rd), W'(1));
    repeat ($urandom_range(0, 2)) tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_sd_rd", W'(sd_bus.sd_rd), W'(0));
    chk("rst_mid_cpu_wait", W'(cpu_wait), W'(0));
    chk("rst_mid_busy", W'(busy), W'(0));
    tick();
    reset = 1'b0;
    exp_q.delete();
    m_cur   = 63;
    m_dirty = '0;
    m_valid = 1'b0;
    model_track_check();
    tick();
    serve(50, 1'b1, -1);
    change_track(21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fdd_track_ctrl.md
FDD_TRACK_CTRL -- requirements
Module: fdd_track_ctrl

Interface
REQ-001 SHALL have parameter SECTORS, default 13: 512-byte sectors per track image.
REQ-002 SHALL have parameter IDLE_FLUSH, default 1400000: clk_sys cycles without a disk write before a background flush (~100 ms at 14 MHz).
REQ-003 SHALL have port clk_sys, input, 1: the only clock.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port track, input, 6: head position from the disk controller.
REQ-006 SHALL have port img_mounted, input, 1: one-cycle pulse when a new image is mounted.
REQ-007 SHALL have port img_size_nz, input, 1: mounted image is non-empty.
REQ-008 SHALL have port img_readonly, input, 1: mounted image is write-protected.
REQ-009 SHALL have port fd_write_disk, input, 1: one-cycle track-buffer write strobe.
REQ-010 SHALL have port fd_track_addr, input, 14: track-buffer byte address; bits [12:9] give the sector.
REQ-011 SHALL have port sd_ack, input, 1: SD channel acknowledge.
REQ-012 SHALL have port sd_lba, output, 32: sector LBA.
REQ-013 SHALL have port sd_rd, output, 1: sector read request.
REQ-014 SHALL have port sd_wr, output, 1: sector write request.
REQ-015 SHALL have port track_sec, output, 4: buffer sector selected for the SD transfer.
REQ-016 SHALL have port cpu_wait, output, 1: CPU stall.
REQ-017 SHALL have port busy, output, 1: any SD transfer in progress.

Function
REQ-018 SHALL implement states IDLE, FLUSH_REQ, FLUSH_XFER, LOAD_REQ, LOAD_XFER.
REQ-019 SHALL keep a SECTORS-bit dirty mask plus cur_track (6 bits) and a valid flag.
REQ-020 SHALL set the dirty bit fd_track_addr[12:9] on fd_write_disk when valid=1, img_readonly=0, the sector is below SECTORS and state is not LOAD_*; in every other case the strobe SHALL be ignored.
REQ-021 SHALL, in IDLE, start a transfer when track differs from cur_track or a pending-mount flag is set. It SHALL go to FLUSH_REQ if the dirty mask is non-zero and no mount is pending; otherwise it SHALL go to LOAD_REQ. cpu_wait SHALL be asserted in the same cycle.
REQ-022 SHALL, in IDLE, go to FLUSH_REQ with cpu_wait=0 (background flush) when the dirty mask is non-zero and the idle counter reaches IDLE_FLUSH.
REQ-023 SHALL, in FLUSH_REQ, select the lowest set dirty bit s and drive sd_lba = SECTORS*cur_track + s, track_sec = s and sd_wr = 1.
REQ-024 SHALL, in LOAD_REQ, use load index s from 0 to SECTORS-1 and drive sd_lba = SECTORS*track_latched + s, track_sec = s and sd_rd = 1.
REQ-025 SHALL hold sd_rd/sd_wr until the rising edge of sd_ack and drop it in the next cycle. On the ack rising edge of a write it SHALL clear dirty[s]; a write strobe to s in that same cycle SHALL win and leave the bit set.
REQ-026 SHALL treat the falling edge of sd_ack as sector completion: next dirty sector, else IDLE (background) or LOAD_REQ (track change); next load index, else IDLE with valid=1 and cur_track=track_latched.
REQ-027 SHALL latch track_latched on entry to LOAD_REQ; a track change during a load SHALL be served by the IDLE check after the load completes.
REQ-028 SHALL, on img_mounted, clear the dirty mask and valid and set pending-mount. An in-progress transfer SHALL finish its current sector and then go to LOAD_REQ.
REQ-029 SHALL skip the load when img_size_nz=0: return to IDLE with valid=0 and cpu_wait=0.
REQ-030 SHALL assert cpu_wait from the track-change detect until the final load completion; it SHALL deassert in the cycle IDLE is re-entered.
REQ-031 SHALL assert busy in every non-IDLE state.
REQ-032 SHALL compute the LBA in 32 bits with no wrap (maximum 831).
REQ-033 SHALL reset the idle counter on every accepted write strobe and saturate it at IDLE_FLUSH.

Reset
REQ-034 SHALL, while reset=1, force state=IDLE, sd_rd=0, sd_wr=0, cpu_wait=0, busy=0, sd_lba=0, track_sec=0, dirty=0, valid=0, pending-mount=0, idle counter=0 and cur_track=6'h3F, so the first track forces a load. A reset in the middle of a transfer SHALL abandon it and drop the requests in the next cycle.

Structure
REQ-035 SHALL place the state enum, SECTORS default and LBA width in the shared package apple2_disk_pkg.
REQ-036 SHALL use one sub-module, fdd_dirty_pick: a combinational lowest-set-bit encoder over the dirty mask producing index and any.

Verification
REQ-037 Reset, mount (img_size_nz=1), track=0 -> 13 reads at LBA 0..12 with track_sec 0..12, cpu_wait high throughout, valid=1 at the end.
REQ-038 Writes to sectors 3 and 7 of track 5, then track=6 -> writes at LBA 68 and 72, then reads at LBA 78..90, with cpu_wait high across both phases.
REQ-039 Write sector 2 then idle for IDLE_FLUSH cycles -> one sd_wr at LBA 13*track+2 with cpu_wait=0, and dirty cleared.
REQ-040 Write strobe to sector 4 in the same cycle as the sd_ack rising edge of sector 4's flush -> dirty[4] stays set and a second write is issued.
REQ-041 img_readonly=1 with writes, then a track change -> no sd_wr; loads only.
REQ-042 reset asserted while sd_rd is high -> sd_rd, cpu_wait and busy are 0 one cycle later, and the next track change reloads fully.
